// File: rtl/imem_axi_read_slave.sv
// AXI4 read-only slave in front of an instruction-memory word array.
// One beat is outstanding at a time: each beat takes a FETCH cycle (array read)
// followed by a SEND cycle (R channel presentation until RREADY).
module imem_axi_read_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = 10
) (
    input  logic             clk,
    input  logic             rst,
    // AR channel
    input  logic [31:0]      S_AXI_ARADDR,
    input  logic [7:0]       S_AXI_ARLEN,
    input  logic [2:0]       S_AXI_ARSIZE,
    input  logic [1:0]       S_AXI_ARBURST,
    input  logic [2:0]       S_AXI_ARPROT,
    input  logic             S_AXI_ARVALID,
    output logic             S_AXI_ARREADY,
    // R channel
    output logic [31:0]      S_AXI_RDATA,
    output logic [1:0]       S_AXI_RRESP,
    output logic             S_AXI_RLAST,
    output logic             S_AXI_RVALID,
    input  logic             S_AXI_RREADY,
    // boot/debug load port
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [31:0]      load_data
);

    localparam int unsigned DATA_W     = 32;
    localparam logic [31:0] MEM_BYTES  = 32'(DEPTH_WORDS * 4);
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  BURST_FIXED = 2'b00;
    localparam logic [1:0]  BURST_WRAP  = 2'b10;
    localparam logic [1:0]  BURST_RSVD  = 2'b11;
    localparam logic [2:0]  SIZE_WORD   = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [1:0]          burst_q, burst_d;
    logic                err_q, err_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                arready_q, arready_d;
    logic                rvalid_q, rvalid_d;
    logic                rlast_q, rlast_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;

    logic [DATA_W-1:0]   mem_q [DEPTH_WORDS];

    logic                ar_hs_c;
    logic                ar_err_c;
    logic                wrap_len_ok_c;
    logic [31:0]         beat_off_c;
    logic                beat_bad_c;
    logic [IDX_W-1:0]    beat_idx_c;
    logic [31:0]         wrap_mask_c;
    logic [31:0]         next_addr_c;
    logic                unused_c;

    // Protection bits and byte-offset bits of the address carry no meaning here.
    assign unused_c = ^{S_AXI_ARPROT, S_AXI_ARADDR[1:0]};

    // Request legality: only word-sized FIXED/INCR bursts and power-of-two WRAPs up to 16 beats.
    assign ar_hs_c       = S_AXI_ARVALID & arready_q;
    assign wrap_len_ok_c = (S_AXI_ARLEN == 8'd1) | (S_AXI_ARLEN == 8'd3) |
                           (S_AXI_ARLEN == 8'd7) | (S_AXI_ARLEN == 8'd15);
    assign ar_err_c      = (S_AXI_ARSIZE != SIZE_WORD) |
                           (S_AXI_ARBURST == BURST_RSVD) |
                           (S_AXI_ARLEN > 8'd15) |
                           ((S_AXI_ARBURST == BURST_WRAP) & ~wrap_len_ok_c);

    // Per-beat decode: offset from the array base, range check, word index.
    assign beat_off_c = addr_q - BASE_ADDR;
    assign beat_bad_c = err_q | (beat_off_c >= MEM_BYTES);
    assign beat_idx_c = beat_off_c[IDX_W+1:2];

    // WRAP container is (len+1)*4 bytes; for legal lengths that mask is len*4+3.
    assign wrap_mask_c = 32'({len_q, 2'b11});

    // Address of the following beat for each burst type.
    always_comb begin
        next_addr_c = addr_q + 32'd4;
        case (burst_q)
            BURST_FIXED: next_addr_c = addr_q;
            BURST_WRAP:  next_addr_c = (addr_q & ~wrap_mask_c) |
                                       ((addr_q + 32'd4) & wrap_mask_c);
            default:     next_addr_c = addr_q + 32'd4;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        burst_d   = burst_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        case (state_q)
            ST_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs_c) begin
                    addr_d    = {S_AXI_ARADDR[31:2], 2'b00};
                    len_d     = S_AXI_ARLEN;
                    burst_d   = S_AXI_ARBURST;
                    err_d     = ar_err_c;
                    cnt_d     = 8'd0;
                    arready_d = 1'b0;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                rvalid_d = 1'b1;
                rlast_d  = (cnt_q == len_q);
                if (beat_bad_c) begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                end else begin
                    rdata_d = mem_q[beat_idx_c];
                    rresp_d = RESP_OKAY;
                end
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (S_AXI_RREADY) begin
                    rvalid_d = 1'b0;
                    if (rlast_q) begin
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        addr_d  = next_addr_c;
                        cnt_d   = cnt_q + 8'd1;
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Word array load port; a same-edge FETCH sees the pre-write word.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_idx] <= load_data;
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_imem_axi_read_slave.sv
// Bench for imem_axi_read_slave: directed bursts plus randomized bursts checked
// against an address-arithmetic reference model and a shadow copy of the array.
module tb_imem_axi_read_slave;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned IDX   = 10;

    logic            clk;
    logic            rst;
    logic [31:0]     S_AXI_ARADDR;
    logic [7:0]      S_AXI_ARLEN;
    logic [2:0]      S_AXI_ARSIZE;
    logic [1:0]      S_AXI_ARBURST;
    logic [2:0]      S_AXI_ARPROT;
    logic            S_AXI_ARVALID;
    logic            S_AXI_ARREADY;
    logic [31:0]     S_AXI_RDATA;
    logic [1:0]      S_AXI_RRESP;
    logic            S_AXI_RLAST;
    logic            S_AXI_RVALID;
    logic            S_AXI_RREADY;
    logic            load_en;
    logic [IDX-1:0]  load_idx;
    logic [31:0]     load_data;

    int unsigned     tests;
    int unsigned     fails;
    logic [31:0]     shadow [DEPTH];

    imem_axi_read_slave #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .IDX_W       (IDX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARLEN   (S_AXI_ARLEN),
        .S_AXI_ARSIZE  (S_AXI_ARSIZE),
        .S_AXI_ARBURST (S_AXI_ARBURST),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RLAST   (S_AXI_RLAST),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .load_en       (load_en),
        .load_idx      (load_idx),
        .load_data     (load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something blocks outside the bounded waits.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int unsigned idx, input logic [31:0] val);
        load_en   = 1'b1;
        load_idx  = IDX'(idx);
        load_data = val;
        tick();
        load_en = 1'b0;
        shadow[idx] = val;
    endtask

    // Reference: address of beat k from burst rules, then range/legality and array lookup.
    function automatic void model_beat(input logic [31:0] addr, input int unsigned len,
                                       input logic [2:0] size, input logic [1:0] burst,
                                       input int unsigned k,
                                       output logic [31:0] d, output logic [1:0] r);
        logic [31:0] a0, a, bsz, lo, off;
        bit err;
        err = (size != 3'd2) || (burst == 2'd3) || (len > 15) ||
              (burst == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15));
        a0 = addr & 32'hFFFF_FFFC;
        a  = a0;
        if (burst == 2'd1) begin
            a = a0 + 32'(4 * k);
        end else if (burst == 2'd2 && !err) begin
            bsz = 32'((len + 1) * 4);
            lo  = a0 % bsz;
            a   = a0 - lo + ((lo + 32'(4 * k)) % bsz);
        end
        off = a - BASE;
        if (err || off >= 32'(DEPTH * 4)) begin
            d = 32'd0;
            r = 2'b10;
        end else begin
            d = shadow[off[IDX+1:2]];
            r = 2'b00;
        end
    endfunction

    // One complete burst; optional stall, mid-burst load, abort by reset, random RREADY gaps.
    task automatic run_burst(input logic [31:0] addr, input int unsigned len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input string tag,
                             input int stall_beat = -1, input int stall_cyc = 0,
                             input int load_beat = -1, input int unsigned load_w = 0,
                             input logic [31:0] load_val = 32'd0,
                             input int abort_beat = -1, input bit rand_stall = 1'b0);
        int          n;
        int          cyc;
        logic [31:0] ed;
        logic [1:0]  er;
        n = 0;
        while (S_AXI_ARREADY !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (S_AXI_ARREADY !== 1'b1) begin
            check($sformatf("%s_arready_wait", tag), 32'(S_AXI_ARREADY), 32'd1);
            return;
        end
        S_AXI_ARADDR  = addr;
        S_AXI_ARLEN   = 8'(len);
        S_AXI_ARSIZE  = size;
        S_AXI_ARBURST = burst;
        S_AXI_ARPROT  = 3'($urandom_range(0, 7));
        S_AXI_ARVALID = 1'b1;
        model_beat(addr, len, size, burst, 0, ed, er);
        tick();
        check($sformatf("%s_arready_drop", tag), 32'(S_AXI_ARREADY), 32'd0);
        check($sformatf("%s_lat1", tag), 32'(S_AXI_RVALID), 32'd0);
        tick();
        check($sformatf("%s_lat2", tag), 32'(S_AXI_RVALID), 32'd1);
        for (int k = 0; k <= int'(len); k++) begin
            n = 0;
            while (S_AXI_RVALID !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            if (S_AXI_RVALID !== 1'b1) begin
                check($sformatf("%s_b%0d_rvalid_wait", tag, k), 32'(S_AXI_RVALID), 32'd1);
                S_AXI_ARVALID = 1'b0;
                return;
            end
            check($sformatf("%s_b%0d_data", tag, k), S_AXI_RDATA, ed);
            check($sformatf("%s_b%0d_resp", tag, k), 32'(S_AXI_RRESP), 32'(er));
            check($sformatf("%s_b%0d_last", tag, k), 32'(S_AXI_RLAST), 32'(k == int'(len)));
            check($sformatf("%s_b%0d_arready_busy", tag, k), 32'(S_AXI_ARREADY), 32'd0);
            if (k == abort_beat) begin
                rst = 1'b1;
                #1;
                check($sformatf("%s_rst_rvalid", tag), 32'(S_AXI_RVALID), 32'd0);
                check($sformatf("%s_rst_rlast", tag), 32'(S_AXI_RLAST), 32'd0);
                check($sformatf("%s_rst_rdata", tag), S_AXI_RDATA, 32'd0);
                check($sformatf("%s_rst_arready", tag), 32'(S_AXI_ARREADY), 32'd0);
                S_AXI_ARVALID = 1'b0;
                S_AXI_RREADY  = 1'b0;
                return;
            end
            if (k == int'(len)) S_AXI_ARVALID = 1'b0;
            cyc = (k == stall_beat) ? stall_cyc : (rand_stall ? int'($urandom_range(0, 2)) : 0);
            S_AXI_RREADY = 1'b0;
            for (int s = 0; s < cyc; s++) begin
                tick();
                check($sformatf("%s_b%0d_hold_valid", tag, k), 32'(S_AXI_RVALID), 32'd1);
                check($sformatf("%s_b%0d_hold_data", tag, k), S_AXI_RDATA, ed);
            end
            S_AXI_RREADY = 1'b1;
            tick();
            S_AXI_RREADY = 1'b0;
            check($sformatf("%s_b%0d_gap", tag, k), 32'(S_AXI_RVALID), 32'd0);
            if (k < int'(len)) begin
                model_beat(addr, len, size, burst, k + 1, ed, er);
                if (k + 1 == load_beat) load_word(load_w, load_val);
            end
        end
        check($sformatf("%s_rearm", tag), 32'(S_AXI_ARREADY), 32'd1);
    endtask

    initial begin
        int unsigned sel;
        int unsigned rl;
        logic [31:0] ra;
        logic [1:0]  rb;
        logic [2:0]  rs;

        tests = 0;
        fails = 0;
        rst = 1'b1;
        S_AXI_ARADDR  = '0;
        S_AXI_ARLEN   = '0;
        S_AXI_ARSIZE  = 3'b010;
        S_AXI_ARBURST = 2'b01;
        S_AXI_ARPROT  = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;
        load_en       = 1'b0;
        load_idx      = '0;
        load_data     = '0;

        // Reset values
        repeat (3) tick();
        check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
        check("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
        check("rst_rlast", 32'(S_AXI_RLAST), 32'd0);
        check("rst_rdata", S_AXI_RDATA, 32'd0);
        check("rst_rresp", 32'(S_AXI_RRESP), 32'd0);
        rst = 1'b0;
        check("rel_arready_pre", 32'(S_AXI_ARREADY), 32'd0);
        tick();
        check("rel_arready", 32'(S_AXI_ARREADY), 32'd1);

        // Fill the array, then the directed pattern words
        for (int i = 0; i < int'(DEPTH); i++) load_word(i, $urandom);
        for (int i = 0; i < 4; i++) load_word(i, 32'hA0 + 32'(i));

        run_burst(BASE, 3, 3'b010, 2'b01, "incr4");
        run_burst(BASE + 32'd8, 3, 3'b010, 2'b10, "wrap4");
        run_burst(BASE, 2, 3'b010, 2'b10, "wrap_len2");
        run_burst(BASE, 3, 3'b010, 2'b01, "stall", 1, 5);
        run_burst(BASE + 32'(4 * (DEPTH - 2)), 3, 3'b010, 2'b01, "top_edge");
        run_burst(BASE - 32'd8, 3, 3'b010, 2'b01, "below_base");
        run_burst(BASE + 32'd6, 1, 3'b010, 2'b01, "unaligned");

        // Reset in the middle of a 16-beat burst, then a clean burst
        run_burst(BASE, 15, 3'b010, 2'b01, "abort", -1, 0, -1, 0, 32'd0, 1);
        tick();
        tick();
        rst = 1'b0;
        check("abort_arready_pre", 32'(S_AXI_ARREADY), 32'd0);
        tick();
        check("abort_arready_post", 32'(S_AXI_ARREADY), 32'd1);
        run_burst(BASE + 32'd4, 2, 3'b010, 2'b01, "post_rst");

        // FIXED burst with a load landing on the FETCH of beat 2
        load_word(5, 32'h0000_0011);
        run_burst(BASE + 32'd20, 3, 3'b010, 2'b00, "fixed_load", -1, 0, 1, 5, 32'h0000_0055);
        check("fixed_load_shadow", shadow[5], 32'h0000_0055);
        run_burst(BASE, 3, 3'b001, 2'b01, "size_bad");
        run_burst(BASE, 1, 3'b010, 2'b11, "burst_rsvd");
        run_burst(BASE, 17, 3'b010, 2'b01, "len_big");

        // Randomized bursts with random RREADY gaps and occasional loads
        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 3);
            if (sel < 3) ra = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            else ra = BASE + 32'(4 * $urandom_range(DEPTH - 20, DEPTH + 20));
            ra = ra + 32'($urandom_range(0, 3));
            rb = 2'($urandom_range(0, 3));
            rl = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0) rl = $urandom_range(16, 20);
            else if (rb == 2'b10 && $urandom_range(0, 3) != 0) rl = (1 << $urandom_range(1, 4)) - 1;
            rs = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            if ($urandom_range(0, 3) == 0) load_word($urandom_range(0, DEPTH - 1), $urandom);
            run_burst(ra, rl, rs, rb, $sformatf("rnd%0d", t), -1, 0, -1, 0, 32'd0, -1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
